// File: rtl/nano_apb_pkg.sv
// Shared definitions for the nano APB master: FSM state encoding, default
// parameters and the timeout counter width helper.
package nano_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int DEF_ADDR_W         = 12;
   localparam int DEF_TIMEOUT_CYCLES = 255;

   function automatic int tmo_cnt_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction

   localparam int DEF_TMO_CNT_W = tmo_cnt_w(DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/nano_apb_timeout.sv
// Wait-state counter for the nano APB master; hit_o flags the stalled ACCESS
// cycle on which the count reaches TIMEOUT_CYCLES.
module nano_apb_timeout
   import nano_apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = tmo_cnt_w(TIMEOUT_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic inc_i,
   output logic hit_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: cleared when a transfer is accepted, bumped per stalled cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (inc_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = inc_i & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/nano_apb_master.sv
// Single-outstanding APB master bridging a valid/ready host request port.
// Optional wait-state abort enabled by NANO_APB_MASTER_TIMEOUT_EN.
module nano_apb_master
   import nano_apb_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              host_req_valid,
   output logic              host_req_ready,
   input  logic [ADDR_W-1:0] host_req_addr,
   input  logic              host_req_write,
   input  logic [31:0]       host_req_wdata,
   output logic              host_rsp_valid,
   output logic [31:0]       host_rsp_rdata,
   output logic              host_rsp_err,
   output logic              apb_psel,
   output logic              apb_penable,
   output logic              apb_pwrite,
   output logic [ADDR_W-1:0] apb_paddr,
   output logic [31:0]       apb_pwdata,
   input  logic [31:0]       apb_prdata,
   input  logic              apb_pready,
   input  logic              apb_pslverr
);

   apb_state_e        state_q;
   logic              ready_q;
   logic              psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [31:0]       pwdata_q;
   logic              rsp_valid_q;
   logic [31:0]       rsp_rdata_q;
   logic              rsp_err_q;

   logic              accept_s;
   logic              tmo_hit_s;

   assign accept_s = host_req_valid & ready_q;

`ifdef NANO_APB_MASTER_TIMEOUT_EN
   logic stall_s;
   assign stall_s = (state_q == ST_ACCESS) & ~apb_pready;

   nano_apb_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (accept_s),
      .inc_i (stall_s),
      .hit_o (tmo_hit_s)
   );
`else
   // Never true for a sane parameter: ACCESS waits for pready indefinitely.
   assign tmo_hit_s = (TIMEOUT_CYCLES < 0);
`endif

   // Transfer FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b1;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= {ADDR_W{1'b0}};
         pwdata_q    <= 32'h0000_0000;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  paddr_q   <= host_req_addr;
                  pwrite_q  <= host_req_write;
                  pwdata_q  <= host_req_wdata;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
                  ready_q   <= 1'b0;
                  state_q   <= ST_SETUP;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (apb_pready) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  ready_q     <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= apb_pslverr;
                  rsp_rdata_q <= pwrite_q ? 32'h0000_0000 : apb_prdata;
                  state_q     <= ST_IDLE;
               end else if (tmo_hit_s) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  ready_q     <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= 32'h0000_0000;
                  state_q     <= ST_IDLE;
               end else begin
                  state_q <= ST_ACCESS;
               end
            end
            default: begin
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
               ready_q   <= 1'b1;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign host_req_ready = ready_q;
   assign host_rsp_valid = rsp_valid_q;
   assign host_rsp_rdata = rsp_rdata_q;
   assign host_rsp_err   = rsp_err_q;
   assign apb_psel       = psel_q;
   assign apb_penable    = penable_q;
   assign apb_pwrite     = pwrite_q;
   assign apb_paddr      = paddr_q;
   assign apb_pwdata     = pwdata_q;

endmodule
